// File: rtl/squeeze_bank_writer_if.sv
// rtl/squeeze_bank_writer_if.sv - channel stream in, bank write port out
interface squeeze_bank_writer_if #(
  parameter int DW  = 16,
  parameter int NCH = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic              wren;
  logic [31:0]       wr_addr;
  logic [NCH*DW-1:0] datain;

  // upstream source plus bank side (stimulus / environment)
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  wren,
    input  wr_addr,
    input  datain
  );

  // the writer itself
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output wren,
    output wr_addr,
    output datain
  );
endinterface

// File: rtl/squeeze_bank_writer.sv
// rtl/squeeze_bank_writer.sv - packs 8 serial channel results per pixel into bank words
module squeeze_bank_writer #(
  parameter int NCH  = 8,
  parameter int DW   = 16,
  parameter int NPIX = 111 * 111,
  parameter bit RELU = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  squeeze_bank_writer_if.slave bus
);

  localparam int            LW        = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(NCH - 1);
  localparam logic [31:0]   LAST_PIX  = 32'(NPIX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [LW-1:0]     lane_cnt_q;
  logic [31:0]       pix_cnt_q;
  logic [DW-1:0]     lane_q [NCH];
  logic [31:0]       wr_addr_q;
  logic [NCH*DW-1:0] datain_q;

  logic              accept;
  logic [DW-1:0]     beat;
  logic [NCH*DW-1:0] packed_word;

  // a beat lands only while filling; in_ready is a pure function of state
  assign accept = bus.in_valid && (state_q == FILL);

  assign bus.wr_addr = wr_addr_q;
  assign bus.datain  = datain_q;

  // ReLU clamp: negative (sign bit set) results become zero when enabled
  always_comb begin
    beat = bus.in_data;
    if (RELU && bus.in_data[DW-1]) begin
      beat = '0;
    end
  end

  // word as it looks once the current beat is placed in its lane, so the
  // last beat of a pixel can be registered straight into datain
  always_comb begin
    packed_word = '0;
    for (int k = 0; k < NCH; k++) begin
      packed_word[DW*k +: DW] = (lane_cnt_q == LW'(k)) ? beat : lane_q[k];
    end
  end

  // next state and state-decoded handshake/status outputs
  always_comb begin
    state_d      = state_q;
    bus.in_ready = 1'b0;
    bus.wren     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
        end
      end
      FILL: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
        if (bus.in_valid && (lane_cnt_q == LAST_LANE)) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        bus.wren = 1'b1;
        busy     = 1'b1;
        state_d  = (pix_cnt_q == LAST_PIX) ? DONE : FILL;
      end
      DONE: begin
        done    = 1'b1;
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state register; reset aborts any map in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // lane capture, counters and the registered bank write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_cnt_q <= '0;
      pix_cnt_q  <= '0;
      wr_addr_q  <= '0;
      datain_q   <= '0;
      for (int k = 0; k < NCH; k++) begin
        lane_q[k] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            pix_cnt_q  <= '0;
            lane_cnt_q <= '0;
          end
        end
        FILL: begin
          if (accept) begin
            lane_q[lane_cnt_q] <= beat;
            if (lane_cnt_q == LAST_LANE) begin
              lane_cnt_q <= '0;
              datain_q   <= packed_word;
              wr_addr_q  <= pix_cnt_q;
            end else begin
              lane_cnt_q <= lane_cnt_q + 1'b1;
            end
          end
        end
        WRITE: begin
          // the final address is held; the counter never wraps
          if (pix_cnt_q != LAST_PIX) begin
            pix_cnt_q <= pix_cnt_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_squeeze_bank_writer.sv
// tb/tb_squeeze_bank_writer.sv - self-checking bench for squeeze_bank_writer
module tb_squeeze_bank_writer;
  localparam int NP0 = 600;
  localparam int NP1 = 4;

  typedef struct packed {
    logic [7:0][15:0] b;
    logic [127:0]     e1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        drv_start;
  logic        drv_valid;
  logic [15:0] drv_data;
  logic        busy0, done0, busy1, done1;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  squeeze_bank_writer_if #(.DW(16), .NCH(8)) bif0 ();
  squeeze_bank_writer_if #(.DW(16), .NCH(8)) bif1 ();

  assign bif0.in_valid = drv_valid & ~sel;
  assign bif0.in_data  = drv_data;
  assign bif1.in_valid = drv_valid & sel;
  assign bif1.in_data  = drv_data;

  squeeze_bank_writer #(.NCH(8), .DW(16), .NPIX(NP0), .RELU(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .start(drv_start & ~sel),
    .busy(busy0), .done(done0), .bus(bif0.slave));

  squeeze_bank_writer #(.NCH(8), .DW(16), .NPIX(NP1), .RELU(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .start(drv_start & sel),
    .busy(busy1), .done(done1), .bus(bif1.slave));

  logic         m_ready, m_wren, m_busy, m_done;
  logic [31:0]  m_addr;
  logic [127:0] m_data;
  assign m_ready = sel ? bif1.in_ready : bif0.in_ready;
  assign m_wren  = sel ? bif1.wren     : bif0.wren;
  assign m_busy  = sel ? busy1         : busy0;
  assign m_done  = sel ? done1         : done0;
  assign m_addr  = sel ? bif1.wr_addr  : bif0.wr_addr;
  assign m_data  = sel ? bif1.datain   : bif0.datain;

  // monitor: log every bank write, done pulse and busy fall of the selected writer
  int           w_cyc[$];
  logic [31:0]  w_addr[$];
  logic [127:0] w_data[$];
  int           d_cyc[$];
  int           bf_cyc[$];
  logic         prev_busy = 1'b0;
  int           both_hi = 0;

  always @(negedge clk) begin
    if (m_wren) begin
      w_cyc.push_back(cyc);
      w_addr.push_back(m_addr);
      w_data.push_back(m_data);
    end
    if (m_done) d_cyc.push_back(cyc);
    if (prev_busy && !m_busy) bf_cyc.push_back(cyc);
    if (m_wren && m_done) both_hi <= both_hi + 1;
    prev_busy <= m_busy;
  end

  // reference model state
  logic [15:0] stim[$];
  int          acc[$];
  int          fed;
  vec_t        tv[4];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] relu_m(input logic [15:0] x, input bit on);
    return (on && x >= 16'h8000) ? 16'h0000 : x;
  endfunction

  function automatic logic [127:0] pack_m(input int p, input bit on);
    logic [127:0] w = '0;
    for (int k = 0; k < 8; k++) begin
      w = w | ({112'b0, relu_m(stim[8*p+k], on)} << (16*k));
    end
    return w;
  endfunction

  task automatic new_map();
    stim.delete(); acc.delete(); fed = 0;
    w_cyc.delete(); w_addr.delete(); w_data.delete(); d_cyc.delete(); bf_cyc.delete();
    both_hi = 0;
  endtask

  task automatic do_start();
    @(negedge clk); drv_start = 1'b1;
    @(negedge clk); drv_start = 1'b0;
    chki("busy_after_start", int'(m_busy), 1);
  endtask

  // pv: percent valid, negative means strict 1/0 toggling; poke sprinkles stray starts
  task automatic feed(input int pv, input bit poke, input int upto);
    int budget = 0;
    bit tog = 1'b0;
    while (fed < upto) begin
      @(negedge clk);
      if (pv < 0) begin
        tog = ~tog;
        drv_valid = tog;
      end else begin
        drv_valid = ($urandom_range(0, 99) < pv);
      end
      drv_data  = drv_valid ? stim[fed] : 16'($urandom);
      drv_start = poke && ($urandom_range(0, 29) == 0);
      if (drv_valid && m_ready) begin
        acc.push_back(cyc);
        fed++;
      end
      budget++;
      if (budget > 40 * upto + 100) begin
        chki("feed_timeout", fed, upto);
        break;
      end
    end
    @(negedge clk);
    drv_valid = 1'b0;
    drv_start = 1'b0;
  endtask

  task automatic check_map(input int npix, input bit on, input bit expect_done);
    int n;
    chki("wren_count", w_addr.size(), npix);
    n = (w_addr.size() < npix) ? w_addr.size() : npix;
    for (int i = 0; i < n; i++) begin
      chki("wr_addr", int'(w_addr[i]), i);
      chk("datain", w_data[i], pack_m(i, on));
      if (8*i+7 < acc.size()) chki("wren_latency", w_cyc[i], acc[8*i+7] + 1);
    end
    if (expect_done) begin
      chki("done_count", d_cyc.size(), 1);
      if (d_cyc.size() > 0 && n > 0) begin
        chki("done_after_wren", d_cyc[0], w_cyc[n-1] + 1);
        chki("busy_fall", (bf_cyc.size() > 0) ? bf_cyc[0] : -1, d_cyc[0] + 1);
      end
    end else begin
      chki("no_done", d_cyc.size(), 0);
    end
    chki("wren_and_done", both_hi, 0);
  endtask

  initial begin
    tv[0].b  = {16'h0008, 16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001};
    tv[0].e1 = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    tv[1].b  = {16'h0080, 16'h0070, 16'h0060, 16'h0050, 16'h8005, 16'h0030, 16'h0020, 16'h0010};
    tv[1].e1 = 128'h0080_0070_0060_0050_0000_0030_0020_0010;
    tv[2].b  = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h7FFF};
    tv[2].e1 = 128'h0000_0000_0000_0000_0000_0000_0000_7FFF;
    tv[3].b  = {16'h4000, 16'hC000, 16'h1234, 16'hABCD, 16'h0000, 16'h8001, 16'h7FFF, 16'h8000};
    tv[3].e1 = 128'h4000_0000_1234_0000_0000_0000_7FFF_0000;

    rst = 1'b0; sel = 1'b0; drv_start = 1'b0; drv_valid = 1'b0; drv_data = '0;
    new_map();

    // reset with random inputs: everything quiet
    repeat (3) begin
      @(negedge clk);
      drv_valid = 1'($urandom); drv_start = 1'($urandom); drv_data = 16'($urandom);
      #1;
      chk("reset_ctl0", {124'b0, busy0, done0, bif0.in_ready, bif0.wren}, '0);
      chk("reset_ctl1", {124'b0, busy1, done1, bif1.in_ready, bif1.wren}, '0);
      chk("reset_addr", {96'b0, bif0.wr_addr}, '0);
      chk("reset_data", bif0.datain, '0);
    end
    @(negedge clk);
    drv_valid = 1'b0; drv_start = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    chki("idle_no_ready", int'(m_ready), 0);

    // one full map on the RELU=1 writer: table pixels, toggled pixel, then random
    new_map();
    for (int p = 0; p < 4; p++) for (int k = 0; k < 8; k++) stim.push_back(tv[p].b[k]);
    while (stim.size() < NP0 * 8) stim.push_back(16'($urandom));
    do_start();
    chki("ready_in_fill", int'(m_ready), 1);
    feed(100, 1'b0, 8);
    chki("p0_wren", int'(m_wren), 1);
    chki("p0_ready_in_write", int'(m_ready), 0);
    chki("p0_addr", int'(m_addr), 0);
    chk("p0_data", m_data, tv[0].e1);
    @(negedge clk);
    chki("p0_ready_again", int'(m_ready), 1);
    chki("p0_wren_single", int'(m_wren), 0);
    feed(100, 1'b0, 32);
    feed(-1, 1'b0, 40);
    for (int i = 0; i < 4; i++) begin
      if (i < w_data.size()) chk("table_relu1", w_data[i], tv[i].e1);
    end
    feed(70, 1'b1, NP0 * 8);
    repeat (5) @(negedge clk);
    check_map(NP0, 1'b1, 1'b1);
    chki("idle_after_map", int'(m_busy), 0);

    // the RELU=0 writer passes negatives through unchanged
    sel = 1'b1;
    new_map();
    for (int p = 0; p < 4; p++) for (int k = 0; k < 8; k++) stim.push_back(tv[p].b[k]);
    do_start();
    feed(80, 1'b0, 32);
    repeat (5) @(negedge clk);
    check_map(NP1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i < w_data.size()) chk("table_relu0", w_data[i], tv[i].b);
    end

    // reset at pixel 500, lane 4, then a fresh map
    sel = 1'b0;
    new_map();
    repeat (500 * 8 + 4) stim.push_back(16'($urandom));
    do_start();
    feed(100, 1'b0, 500 * 8 + 4);
    chki("pre_abort_ready", int'(m_ready), 1);
    rst = 1'b0;
    #1;
    chk("abort_ctl", {124'b0, busy0, done0, bif0.in_ready, bif0.wren}, '0);
    chk("abort_addr", {96'b0, bif0.wr_addr}, '0);
    chk("abort_data", bif0.datain, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_map(500, 1'b1, 1'b0);
    chki("no_restart_ready", int'(m_ready), 0);
    chki("no_restart_busy", int'(m_busy), 0);
    new_map();
    repeat (8) stim.push_back(16'($urandom));
    do_start();
    feed(100, 1'b0, 8);
    chki("fresh_wren", int'(m_wren), 1);
    chki("fresh_addr", int'(m_addr), 0);
    chk("fresh_data", m_data, pack_m(0, 1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
